winograd_hadamard_mac: RTL and testbench

//  Winograd F(4x4,3x3) element-wise stage, directly downstream of kernel_transform_unit.

---
 rtl/winograd_pkg.sv | 19 +
 rtl/hadamard_row_mac.sv | 49 ++++
 rtl/winograd_hadamard_mac.sv | 141 ++++++++++++++
 tb/tb_winograd_hadamard_mac.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/winograd_pkg.sv
// rtl/winograd_pkg.sv - shared types and constants for the Winograd element-wise stage
package winograd_pkg;

  localparam int TILE         = 6;
  localparam int DATA_W       = 16;
  localparam int ACC_W        = 40;
  localparam int HMAC_LATENCY = 8;

  typedef logic [0:TILE-1][0:TILE-1][DATA_W-1:0] u_tile_t;
  typedef logic [0:TILE-1][0:TILE-1][ACC_W-1:0]  m_tile_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    MUL   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } hmac_state_e;

endpackage

// File: rtl/hadamard_row_mac.sv
// rtl/hadamard_row_mac.sv - one row of registered signed multipliers plus accumulate adders
module hadamard_row_mac #(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40,
  parameter int N      = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       mul_en,
  input  logic [0:N-1][DATA_W-1:0]   a_row,
  input  logic [0:N-1][DATA_W-1:0]   b_row,
  input  logic                       clr,
  input  logic [0:N-1][ACC_W-1:0]    acc_row,
  output logic [0:N-1][ACC_W-1:0]    sum_row
);

  logic [0:N-1][ACC_W-1:0]    prod_q;
  logic [0:N-1][ACC_W-1:0]    prod_d;
  logic signed [2*DATA_W-1:0] p [N];

  // Full-precision signed products, sign-extended to the accumulator width.
  always_comb begin
    prod_d = prod_q;
    for (int c = 0; c < N; c++) begin
      p[c] = $signed(a_row[c]) * $signed(b_row[c]);
      if (mul_en) begin
        prod_d[c] = ACC_W'(p[c]);
      end
    end
  end

  // Product register; the adders below consume it on the following edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else begin
      prod_q <= prod_d;
    end
  end

  // Accumulate or replace; two's-complement wrap is intentional.
  always_comb begin
    sum_row = '0;
    for (int c = 0; c < N; c++) begin
      sum_row[c] = (clr ? '0 : acc_row[c]) + prod_q[c];
    end
  end

endmodule

// File: rtl/winograd_hadamard_mac.sv
// rtl/winograd_hadamard_mac.sv - 6x6 Hadamard multiply-accumulate tile, one row per cycle
module winograd_hadamard_mac
  import winograd_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ACC_W  = 40
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   start,
  input  logic                                   acc_clear,
  input  logic [0:TILE-1][0:TILE-1][DATA_W-1:0]  kernel_in,
  input  logic [0:TILE-1][0:TILE-1][DATA_W-1:0]  tile_in,
  output logic [0:TILE-1][0:TILE-1][ACC_W-1:0]   acc_out,
  output logic                                   busy,
  output logic                                   done
);

  generate
    if (ACC_W < 2 * DATA_W) begin : g_acc_w_check
      $error("ACC_W must be at least 2*DATA_W");
    end
  endgenerate

  hmac_state_e                            state_q, state_d;
  logic [2:0]                             row_q, row_d;
  logic [2:0]                             prow_q, prow_d;
  logic                                   pvalid_q, pvalid_d;
  logic                                   clr_q, clr_d;
  logic                                   busy_q, busy_d;
  logic                                   done_q, done_d;
  logic [0:TILE-1][0:TILE-1][DATA_W-1:0]  u_q, u_d;
  logic [0:TILE-1][0:TILE-1][DATA_W-1:0]  v_q, v_d;
  logic [0:TILE-1][0:TILE-1][ACC_W-1:0]   acc_q, acc_d;
  logic                                   mul_en;
  logic [0:TILE-1][ACC_W-1:0]             sum_row;

  hadamard_row_mac #(
    .DATA_W (DATA_W),
    .ACC_W  (ACC_W),
    .N      (TILE)
  ) u_row_mac (
    .clk     (clk),
    .rst_n   (rst_n),
    .mul_en  (mul_en),
    .a_row   (u_q[row_q]),
    .b_row   (v_q[row_q]),
    .clr     (clr_q),
    .acc_row (acc_q[prow_q]),
    .sum_row (sum_row)
  );

  // Sequencer: latch operands on start, walk rows, drain the last product, pulse done.
  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    prow_d   = prow_q;
    pvalid_d = pvalid_q;
    clr_d    = clr_q;
    busy_d   = busy_q;
    done_d   = done_q;
    u_d      = u_q;
    v_d      = v_q;
    acc_d    = acc_q;
    mul_en   = 1'b0;

    // The product row registered last edge lands in its accumulator row now.
    if (pvalid_q) begin
      acc_d[prow_q] = sum_row;
    end

    case (state_q)
      IDLE: begin
        if (start) begin
          u_d     = kernel_in;
          v_d     = tile_in;
          clr_d   = acc_clear;
          row_d   = 3'd0;
          busy_d  = 1'b1;
          state_d = MUL;
        end
      end
      MUL: begin
        mul_en   = 1'b1;
        prow_d   = row_q;
        pvalid_d = 1'b1;
        if (row_q == 3'(TILE - 1)) begin
          row_d   = 3'd0;
          state_d = DRAIN;
        end else begin
          row_d = row_q + 3'd1;
        end
      end
      DRAIN: begin
        pvalid_d = 1'b0;
        done_d   = 1'b1;
        state_d  = DONE;
      end
      DONE: begin
        done_d  = 1'b0;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State registers; reset dominates any concurrent start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      row_q    <= '0;
      prow_q   <= '0;
      pvalid_q <= 1'b0;
      clr_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      u_q      <= '0;
      v_q      <= '0;
      acc_q    <= '0;
    end else begin
      state_q  <= state_d;
      row_q    <= row_d;
      prow_q   <= prow_d;
      pvalid_q <= pvalid_d;
      clr_q    <= clr_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      u_q      <= u_d;
      v_q      <= v_d;
      acc_q    <= acc_d;
    end
  end

  assign acc_out = acc_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_winograd_hadamard_mac.sv
// tb/tb_winograd_hadamard_mac.sv - directed self-checking bench for winograd_hadamard_mac
module tb_winograd_hadamard_mac;
  import winograd_pkg::*;

  logic    clk = 1'b0;
  logic    rst_n;
  logic    start;
  logic    acc_clear;
  u_tile_t kernel_in;
  u_tile_t tile_in;
  m_tile_t acc_out;
  logic    busy;
  logic    done;

  int     checks = 0;
  int     errors = 0;
  longint mdl [0:5][0:5];

  winograd_hadamard_mac #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .acc_clear (acc_clear),
    .kernel_in (kernel_in),
    .tile_in   (tile_in),
    .acc_out   (acc_out),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic longint wrap40(input longint x);
    logic [39:0] t;
    t = x[39:0];
    return longint'($signed(t));
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int ku, input int kv);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        kernel_in[r][c] = 16'(ku);
        tile_in[r][c]   = 16'(kv);
      end
  endtask

  task automatic zero_model();
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        mdl[r][c] = 0;
  endtask

  task automatic start_tile(input bit clr);
    longint p;
    acc_clear = clr;
    start     = 1'b1;
    step();
    start     = 1'b0;
    acc_clear = 1'b0;
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        p = longint'($signed(kernel_in[r][c])) * longint'($signed(tile_in[r][c]));
        mdl[r][c] = wrap40(clr ? p : mdl[r][c] + p);
      end
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (done !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    check({tag, "_latency"}, n, 7);
    step();
    check({tag, "_done_drop"}, done, 0);
    check({tag, "_busy_drop"}, busy, 0);
  endtask

  task automatic check_tile(input string tag);
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        check($sformatf("%s[%0d][%0d]", tag, r, c), $signed(acc_out[r][c]), mdl[r][c]);
  endtask

  initial begin
    int ndone;
    rst_n     = 1'b0;
    start     = 1'b0;
    acc_clear = 1'b0;
    fill(0, 0);
    zero_model();
    step();
    step();
    rst_n = 1'b1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check_tile("reset_acc");

    // 1: clear-and-load, U=1, V=r*6+c, busy/done timing edge by edge
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        kernel_in[r][c] = 16'd1;
        tile_in[r][c]   = 16'(r * 6 + c);
      end
    start_tile(1'b1);
    check("t1_busy_e0", busy, 1);
    for (int e = 1; e <= 8; e++) begin
      step();
      check($sformatf("t1_busy_e%0d", e), busy, (e < 8) ? 1 : 0);
      check($sformatf("t1_done_e%0d", e), done, (e == 7) ? 1 : 0);
    end
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        check($sformatf("t1_acc[%0d][%0d]", r, c), $signed(acc_out[r][c]), r * 6 + c);

    // 2: accumulate the same tile again, then clear with zero operands
    start_tile(1'b0);
    wait_done("t2a");
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++)
        check($sformatf("t2_acc[%0d][%0d]", r, c), $signed(acc_out[r][c]), 2 * (r * 6 + c));
    fill(0, 0);
    start_tile(1'b1);
    wait_done("t2b");
    check_tile("t2_zero");
    check("t2_zero_corner", $signed(acc_out[5][5]), 0);

    // 3: signed extremes over 300 channels, then mixed-sign extreme
    fill(-32768, -32768);
    for (int k = 0; k < 300; k++) begin
      start_tile(k == 0);
      wait_done("t3_ch");
    end
    check("t3_pos_00", $signed(acc_out[0][0]), 64'sd322122547200);
    check("t3_pos_55", $signed(acc_out[5][5]), 64'sd322122547200);
    check_tile("t3_pos");
    fill(-32768, 32767);
    start_tile(1'b1);
    wait_done("t3_neg");
    check("t3_neg_23", $signed(acc_out[2][3]), -64'sd1073709056);
    check_tile("t3_neg");

    // 4: start re-asserted at edges 3 and 7 with different operands
    for (int r = 0; r < 6; r++)
      for (int c = 0; c < 6; c++) begin
        kernel_in[r][c] = 16'd1;
        tile_in[r][c]   = 16'(r * 6 + c);
      end
    start_tile(1'b1);
    step();
    step();
    fill(2, 5);
    acc_clear = 1'b0;
    start     = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    check("t4_done_e7", done, 1);
    ndone = (done === 1'b1) ? 1 : 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    check("t4_done_count", ndone, 1);
    check("t4_busy_idle", busy, 0);
    check("t4_acc_14", $signed(acc_out[1][4]), 10);
    check_tile("t4");

    // 5: reset at edge 4 aborts, then a fresh accumulate-mode start
    fill(3, -4);
    start_tile(1'b1);
    step();
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    zero_model();
    check("t5_busy_rst", busy, 0);
    check("t5_done_rst", done, 0);
    check_tile("t5_zero");
    ndone = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (done === 1'b1) ndone++;
    end
    check("t5_no_done", ndone, 0);
    start_tile(1'b0);
    wait_done("t5_fresh");
    check("t5_acc_23", $signed(acc_out[2][3]), -12);
    check_tile("t5_fresh");

    // reset and start in the same cycle: reset wins
    rst_n = 1'b0;
    start = 1'b1;
    step();
    rst_n = 1'b1;
    start = 1'b0;
    check("rs_busy0", busy, 0);
    step();
    check("rs_busy1", busy, 0);
    zero_model();
    check_tile("rs_acc");

    // 6: four back-to-back channels with varied signed operands
    for (int k = 0; k < 4; k++) begin
      for (int r = 0; r < 6; r++)
        for (int c = 0; c < 6; c++) begin
          kernel_in[r][c] = 16'((r + 1) * (k + 1) - c * 7);
          tile_in[r][c]   = 16'(c * 1000 - r * (k + 3) * 500);
        end
      start_tile(k == 0);
      wait_done($sformatf("t6_ch%0d", k));
    end
    check_tile("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
